// File: rtl/fifo_chk_pkg.sv
// Shared types and constants for the width-converting FIFO checker.
package fifo_chk_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, DRAIN, FLUSH, DONE} state_t;

  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          ERR_W     = 8;

  // Bits needed to hold the values 0..n
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_chk_pattern_gen.sv
// Emits K consecutive descending pattern units (INIT - u), lowest u in the LSBs.
module fifo_chk_pattern_gen #(
  parameter int           N    = 16,
  parameter int           K    = 1,
  parameter logic [N-1:0] INIT = '1
) (
  input  logic           clk,
  input  logic           tb_rst,
  input  logic           clr,
  input  logic           step,
  output logic [N*K-1:0] word
);
  logic [N-1:0] base;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)    base <= INIT;
    else if (clr)  base <= INIT;
    else if (step) base <= base - N'(K);
  end

  for (genvar i = 0; i < K; i++) begin : g_unit
    assign word[i*N +: N] = base - N'(i);
  end
endmodule

// File: rtl/fifo_width_conv_checker.sv
// Traffic generator / checker for a width-converting FIFO.
// Optional FIFO_CHK_THROTTLE_EN: LFSR-driven pseudo-random stalls on wr_en/rd_en.
module fifo_width_conv_checker
  import fifo_chk_pkg::*;
#(
  parameter int WR_W     = 16,
  parameter int RD_W     = 128,
  parameter int WR_BEATS = 8192,
  parameter int MODE     = 0,
  parameter int RD_LAT   = 1,
  parameter int TIMEOUT  = 1024,
  parameter logic [((WR_W < RD_W) ? WR_W : RD_W)-1:0] INIT = '1
) (
  input  logic             clk,
  input  logic             tb_rst,
  input  logic             start,
  output logic [WR_W-1:0]  wr_data,
  output logic             wr_en,
  input  logic             wr_full,
  output logic             rd_en,
  input  logic [RD_W-1:0]  rd_data,
  input  logic             rd_empty,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int N        = (WR_W < RD_W) ? WR_W : RD_W;
  localparam int RD_BEATS = WR_BEATS * WR_W / RD_W;
  localparam int WCW      = cnt_w(WR_BEATS);
  localparam int RCW      = cnt_w(RD_BEATS);
  localparam int SCW      = cnt_w(TIMEOUT);
  localparam int FCW      = cnt_w(RD_LAT);

  state_t state, state_nxt;
  logic [WCW-1:0] wr_cnt;
  logic [RCW-1:0] rd_cnt;
  logic [SCW-1:0] stall;
  logic [FCW-1:0] flush_cnt;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT:0] vld_pipe;
  logic [RD_LAT-1:0][RD_W-1:0] exp_q;
  logic [WR_W-1:0] wr_word;
  logic [RD_W-1:0] exp_word;
  logic kick, active, wr_ok, rd_ok, wr_gate, rd_gate, wr_fin, rd_fin, stall_hit, mismatch;

  assign kick   = start && (state == IDLE || state == DONE);
  assign active = (state == WRITE) || (state == DRAIN);
  assign busy   = active || (state == FLUSH);
  assign done   = (state == DONE);
  assign pass   = done && (err_cnt == '0) && !timeout;

  assign wr_ok = (state == WRITE) && !wr_full && (wr_cnt < WCW'(WR_BEATS));
  assign rd_ok = !rd_empty && (rd_cnt < RCW'(RD_BEATS)) &&
                 ((state == DRAIN) || (MODE == 1 && state == WRITE));

`ifdef FIFO_CHK_THROTTLE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)    lfsr <= LFSR_SEED;
    else if (kick) lfsr <= LFSR_SEED;
    else if (busy) lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  end
  assign wr_gate = lfsr[0];
  assign rd_gate = lfsr[1];
`else
  assign wr_gate = 1'b1;
  assign rd_gate = 1'b1;
`endif

  assign wr_en   = wr_ok && wr_gate;
  assign rd_en   = rd_ok && rd_gate;
  assign wr_data = wr_en ? wr_word : '0;

  // Counts as they will stand after this cycle's strobes
  assign wr_fin = wr_en ? (wr_cnt == WCW'(WR_BEATS - 1)) : (wr_cnt == WCW'(WR_BEATS));
  assign rd_fin = rd_en ? (rd_cnt == RCW'(RD_BEATS - 1)) : (rd_cnt == RCW'(RD_BEATS));
  // stall = cycles since the last strobe, so done lands TIMEOUT cycles after it
  assign stall_hit = active && !(wr_ok || rd_ok) && (stall == SCW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = WRITE;
      WRITE: if (stall_hit) state_nxt = DONE;
             else if (wr_fin) state_nxt = rd_fin ? FLUSH : DRAIN;
      DRAIN: if (stall_hit) state_nxt = DONE;
             else if (rd_fin) state_nxt = FLUSH;
      FLUSH: if (flush_cnt == FCW'(RD_LAT - 1)) state_nxt = DONE;
      DONE:  if (start) state_nxt = WRITE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      stall     <= '0;
      flush_cnt <= '0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (kick) begin
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        stall     <= '0;
        flush_cnt <= '0;
        timeout   <= 1'b0;
        err_cnt   <= '0;
      end else begin
        wr_cnt    <= wr_cnt + WCW'(wr_en);
        rd_cnt    <= rd_cnt + RCW'(rd_en);
        stall     <= !active ? '0 : (wr_ok || rd_ok) ? SCW'(1) : stall + 1'b1;
        flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
        if (stall_hit) timeout <= 1'b1;
        if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  // Expected word travels with the read strobe so it meets rd_data RD_LAT cycles later
  assign vld_pipe = {vld_q, rd_en};
  assign mismatch = busy && vld_pipe[RD_LAT] && (rd_data != exp_q[RD_LAT-1]);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      vld_q <= '0;
      exp_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      exp_q[0] <= exp_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
      if (kick) vld_q <= '0;
    end
  end

  fifo_chk_pattern_gen #(.N(N), .K(WR_W / N), .INIT(INIT)) u_wr_gen (
    .clk(clk), .tb_rst(tb_rst), .clr(kick), .step(wr_en), .word(wr_word)
  );

  fifo_chk_pattern_gen #(.N(N), .K(RD_W / N), .INIT(INIT)) u_exp_gen (
    .clk(clk), .tb_rst(tb_rst), .clr(kick), .step(rd_en), .word(exp_word)
  );
endmodule
